// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel enable, a single
// handshaked configuration port that reloads a channel on its own wrap edge, and a lock indicator.
module clk_div_multi #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 4,
    parameter int LOCK_CYC = 16
) (
    input  logic                                        sys_clk,
    input  logic                                        sys_rst,
    input  logic [N_CH-1:0]                             ch_en,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]                            cfg_div,
    input  logic [CNT_W-1:0]                            cfg_phase,
    output logic [N_CH-1:0]                             clk_out,
    output logic [N_CH-1:0]                             tick,
    output logic                                        locked
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int LK_W = $clog2(LOCK_CYC + 1);
    localparam logic [CH_W:0]    NCH_L   = (CH_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [LK_W-1:0]  LOCK_L  = LK_W'(LOCK_CYC);

    typedef enum logic {IDLE, PEND} state_t;

    state_t            r_state, w_state_next;
    logic [CH_W-1:0]   r_sh_ch;
    logic [CNT_W-1:0]  r_sh_div, r_sh_phase;
    logic [LK_W-1:0]   r_lock;
    logic              w_accept, w_in_range, w_apply;
    logic [CNT_W-1:0]  w_sh_d;
    logic [N_CH-1:0]   w_wrap, r_run, r_clk, r_tick;

    assign w_in_range = ({1'b0, cfg_ch} < NCH_L);
    assign w_sh_d     = (r_sh_div < DIV_MIN) ? DIV_MIN : r_sh_div;
    // A pending config lands on the target's wrap edge, or at once if it is not running.
    assign w_apply    = (r_state == PEND) && (!ch_en[r_sh_ch] || w_wrap[r_sh_ch]);

    assign cfg_ready = (r_state == IDLE);
    assign locked    = (r_lock == LOCK_L);
    assign clk_out   = r_clk;
    assign tick      = r_tick;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_accept = w_in_range;
                    if (w_in_range) w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_apply) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_sh_ch    <= '0;
            r_sh_div   <= '0;
            r_sh_phase <= '0;
            r_lock     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sh_ch    <= cfg_ch;
                r_sh_div   <= cfg_div;
                r_sh_phase <= cfg_phase;
            end
            if (w_accept)
                r_lock <= '0;
            else if (r_state == IDLE && r_lock != LOCK_L)
                r_lock <= r_lock + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt, r_div, w_d, w_d_next, w_cnt_next;
            logic             w_apply_ch;

            assign w_d          = (r_div < DIV_MIN) ? DIV_MIN : r_div;
            assign w_wrap[gi]   = r_run[gi] && (r_cnt == w_d - 1'b1);
            assign w_apply_ch   = w_apply && (r_sh_ch == CH_W'(gi));

            // Outputs are registered from the next count so cnt, clk_out and tick move together.
            always_comb begin
                w_d_next   = w_apply_ch ? w_sh_d : w_d;
                w_cnt_next = '0;
                if (ch_en[gi] && r_run[gi]) begin
                    if (w_apply_ch)
                        w_cnt_next = (r_sh_phase < w_sh_d) ? r_sh_phase : '0;
                    else if (!w_wrap[gi])
                        w_cnt_next = r_cnt + 1'b1;
                end
            end

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_cnt      <= '0;
                    r_div      <= CNT_W'(DIV_INIT);
                    r_run[gi]  <= 1'b0;
                    r_clk[gi]  <= 1'b0;
                    r_tick[gi] <= 1'b0;
                end else begin
                    r_run[gi]  <= ch_en[gi];
                    r_cnt      <= w_cnt_next;
                    if (w_apply_ch) r_div <= w_sh_d;
                    r_clk[gi]  <= ch_en[gi] && (w_cnt_next < (w_d_next >> 1));
                    r_tick[gi] <= ch_en[gi] && (w_cnt_next == '0);
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a 4-channel instance for the main scenarios and a
// 3-channel instance so an out-of-range channel index can actually be driven.
module tb_clk_div_multi;
    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] ch_en;
    logic       cfg_valid, cfg_ready, locked;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div, cfg_phase;
    logic [3:0] clk_out, tick;

    logic [2:0] ch_en_b, clk_out_b, tick_b;
    logic       cfg_valid_b, cfg_ready_b, locked_b;
    logic [1:0] cfg_ch_b;
    logic [7:0] cfg_div_b, cfg_phase_b;

    int checks = 0;
    int failures = 0;
    int k;
    int base[4];
    int dv[4];
    int off[4];
    logic [3:0] en_m;
    logic [3:0] e_clk, e_tick;
    logic [2:0] e_clk_b, e_tick_b;

    always #5 sys_clk = ~sys_clk;

    clk_div_multi #(.N_CH(4), .CNT_W(8), .DIV_INIT(4), .LOCK_CYC(16)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ch_en(ch_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .clk_out(clk_out), .tick(tick), .locked(locked)
    );

    clk_div_multi #(.N_CH(3), .CNT_W(8), .DIV_INIT(4), .LOCK_CYC(16)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ch_en(ch_en_b),
        .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_ch(cfg_ch_b),
        .cfg_div(cfg_div_b), .cfg_phase(cfg_phase_b),
        .clk_out(clk_out_b), .tick(tick_b), .locked(locked_b)
    );

    // Reference: channel c has count (k-base+off) mod dv in output cycle k.
    function automatic void model_out();
        int cn;
        e_clk  = '0;
        e_tick = '0;
        for (int c = 0; c < 4; c++) begin
            if (en_m[c]) begin
                cn = (k - base[c] + off[c]) % dv[c];
                e_clk[c]  = (cn < dv[c] / 2);
                e_tick[c] = (cn == 0);
            end
        end
        e_clk_b  = (((k - 1) % 4) < 2) ? 3'b111 : 3'b000;
        e_tick_b = (((k - 1) % 4) == 0) ? 3'b111 : 3'b000;
    endfunction

    function automatic void model_reset();
        k = 0;
        en_m = 4'hF;
        for (int c = 0; c < 4; c++) begin
            base[c] = 1;
            dv[c]   = 4;
            off[c]  = 0;
        end
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
        k++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        ch_en = 4'hF;
        ch_en_b = 3'b111;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        cfg_valid_b = 1'b0; cfg_ch_b = '0; cfg_div_b = '0; cfg_phase_b = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin
            failures++;
            $display("FAIL reset_outs clk_out=%b tick=%b required 0000/0000", clk_out, tick);
        end
        checks++;
        if (locked !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_status locked=%b cfg_ready=%b required 0/1", locked, cfg_ready);
        end
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_div4_lock();
        for (int i = 0; i < 17; i++) begin
            step();
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                failures++;
                $display("FAIL div4_pattern k=%0d clk_out=%b tick=%b required %b/%b", k, clk_out, tick, e_clk, e_tick);
            end
            checks++;
            if (locked !== (k >= 16)) begin
                failures++;
                $display("FAIL div4_locked k=%0d locked=%b required %b", k, locked, (k >= 16));
            end
        end
    endtask

    task automatic test_cfg_div5();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; cfg_phase = 8'd0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL div5_ready_before cfg_ready=%b required 1", cfg_ready);
        end
        for (int i = 0; i < 23; i++) begin
            step();
            cfg_valid = 1'b0;
            if (k == 21) begin base[1] = 21; dv[1] = 5; end
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                failures++;
                $display("FAIL div5_pattern k=%0d clk_out=%b tick=%b required %b/%b", k, clk_out, tick, e_clk, e_tick);
            end
            checks++;
            if (cfg_ready !== (k >= 21) || locked !== (k >= 37)) begin
                failures++;
                $display("FAIL div5_ready_lock k=%0d ready=%b locked=%b required %b/%b", k, cfg_ready, locked, (k >= 21), (k >= 37));
            end
        end
    endtask

    task automatic test_cfg_phase_and_min();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd6; cfg_phase = 8'd3;
        for (int i = 0; i < 16; i++) begin
            step();
            cfg_valid = 1'b0;
            if (k == 45) begin base[2] = 45; dv[2] = 6; off[2] = 3; end
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick || cfg_ready !== (k >= 45)) begin
                failures++;
                $display("FAIL phase_pattern k=%0d clk_out=%b tick=%b ready=%b required %b/%b/%b", k, clk_out, tick, cfg_ready, e_clk, e_tick, (k >= 45));
            end
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1; cfg_phase = 8'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            cfg_valid = 1'b0;
            if (k == 61) begin base[3] = 61; dv[3] = 2; end
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick || cfg_ready !== (k >= 61)) begin
                failures++;
                $display("FAIL div1_pattern k=%0d clk_out=%b tick=%b ready=%b required %b/%b/%b", k, clk_out, tick, cfg_ready, e_clk, e_tick, (k >= 61));
            end
        end
    endtask

    task automatic test_disable();
        ch_en[0] = 1'b0;
        en_m[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                failures++;
                $display("FAIL disable_pattern k=%0d clk_out=%b tick=%b required %b/%b", k, clk_out, tick, e_clk, e_tick);
            end
        end
        ch_en[0] = 1'b1;
        en_m[0] = 1'b1;
        base[0] = k + 1; dv[0] = 4; off[0] = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                failures++;
                $display("FAIL reenable_pattern k=%0d clk_out=%b tick=%b required %b/%b", k, clk_out, tick, e_clk, e_tick);
            end
        end
    endtask

    task automatic test_bad_channel();
        cfg_valid_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 8'd9; cfg_phase_b = 8'd1;
        checks++;
        if (cfg_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL badch_ready_before cfg_ready=%b required 1", cfg_ready_b);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            cfg_valid_b = 1'b0;
            model_out();
            checks++;
            if (cfg_ready_b !== 1'b1 || locked_b !== 1'b1 || locked !== 1'b1) begin
                failures++;
                $display("FAIL badch_status k=%0d ready_b=%b locked_b=%b locked=%b required 1/1/1", k, cfg_ready_b, locked_b, locked);
            end
            checks++;
            if (clk_out_b !== e_clk_b || tick_b !== e_tick_b) begin
                failures++;
                $display("FAIL badch_pattern k=%0d clk_out=%b tick=%b required %b/%b", k, clk_out_b, tick_b, e_clk_b, e_tick_b);
            end
        end
    endtask

    task automatic test_reset_in_pend();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_phase = 8'd0;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_entered cfg_ready=%b required 0", cfg_ready);
        end
        #3;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || clk_out_b !== 3'h0 || tick_b !== 3'h0) begin
            failures++;
            $display("FAIL async_reset_outs clk_out=%b tick=%b clk_out_b=%b tick_b=%b required zeros", clk_out, tick, clk_out_b, tick_b);
        end
        checks++;
        if (locked !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_status locked=%b cfg_ready=%b required 0/1", locked, cfg_ready);
        end
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            model_out();
            checks++;
            if (clk_out !== e_clk || tick !== e_tick || cfg_ready !== 1'b1) begin
                failures++;
                $display("FAIL post_reset k=%0d clk_out=%b tick=%b ready=%b required %b/%b/1", k, clk_out, tick, cfg_ready, e_clk, e_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div4_lock();
        test_cfg_div5();
        test_cfg_phase_and_min();
        test_disable();
        test_bad_channel();
        test_reset_in_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
